operand_sequencer: RTL and testbench

Drives the serial operand-loading handshake of the polynomial calculator (`go`/`data_in`) from the initiator side. It accepts four 8-bit operands (A, B, C, X) in parallel on a single `start` pulse, then presents them one at a time with press/release `go` phases. It waits for the calculator's two compute cycles, captures the calculator's `data_result`, and reports it with a one-cycle `done` pulse. It sits between a parallel-operand source (test harness or CPU-side register) and the calculator, sharing its clock.

---
 rtl/seq_pkg.sv | 37 +++
 rtl/phase_timer.sv | 27 ++
 rtl/operand_sequencer.sv | 153 +++++++++++++++
 tb/tb_operand_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the operand sequencer: state encoding, operand indices
// and a small elaboration-time helper.
package seq_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] PRESS    = 3'd2;
  localparam logic [2:0] RELEASE  = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  typedef enum logic [2:0] {
    StIdle    = IDLE,
    StSetup   = SETUP,
    StPress   = PRESS,
    StRelease = RELEASE,
    StWaitRes = WAIT_RES,
    StDone    = DONE
  } seq_state_e;

  localparam int unsigned NUM_OPERANDS = 4;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_X = 2'd3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that measures how long the sequencer stays in a phase.
// A phase of N cycles is loaded with N-1; zero marks the last cycle of the phase.
module phase_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/operand_sequencer.sv
// Initiator side of the calculator's serial operand handshake: presents A, B, C, X
// with press/release go phases, waits for the compute, then captures the result.
module operand_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned RESULT_WAIT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] op_c,
  input  logic [7:0] op_x,
  input  logic [7:0] result_in,
  output logic       go,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  localparam int unsigned MaxCycles  = max3(HOLD_CYCLES, GAP_CYCLES, RESULT_WAIT);
  localparam int unsigned TimerWidth = $clog2(MaxCycles + 1);

  seq_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [NUM_OPERANDS-1:0][7:0] op_q;

  logic                  tmr_load;
  logic [TimerWidth-1:0] tmr_value;
  logic                  tmr_zero;

  logic       capture;
  logic       enter_setup;
  logic [7:0] setup_data;

  logic       go_q, busy_q, done_q;
  logic [7:0] data_out_q, result_q;

  phase_timer #(
    .WIDTH(TimerWidth)
  ) u_phase_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load      (tmr_load),
    .load_value(tmr_value),
    .zero      (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    capture     = 1'b0;
    enter_setup = 1'b0;
    setup_data  = op_q[idx_q];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture     = 1'b1;
          idx_d       = IDX_A;
          state_d     = StSetup;
          tmr_load    = 1'b1;
          enter_setup = 1'b1;
          // Operand registers load on this same edge, so drive A straight from the input.
          setup_data  = op_a;
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d   = StPress;
          tmr_load  = 1'b1;
          tmr_value = TimerWidth'(HOLD_CYCLES - 1);
        end
      end
      StPress: begin
        if (tmr_zero) begin
          state_d   = StRelease;
          tmr_load  = 1'b1;
          tmr_value = TimerWidth'(GAP_CYCLES - 1);
        end
      end
      StRelease: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (idx_q == IDX_X) begin
            state_d   = StWaitRes;
            tmr_value = TimerWidth'(RESULT_WAIT - 1);
          end else begin
            idx_d       = idx_q + 2'd1;
            state_d     = StSetup;
            enter_setup = 1'b1;
            setup_data  = op_q[idx_q + 2'd1];
          end
        end
      end
      StWaitRes: begin
        if (tmr_zero) begin
          state_d  = StDone;
          tmr_load = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      idx_q      <= IDX_A;
      op_q       <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        op_q <= {op_x, op_c, op_b, op_a};
      end
      go_q   <= (state_d == StPress);
      busy_q <= (state_d != StIdle);
      done_q <= (state_d == StDone);
      if (state_d == StIdle) begin
        data_out_q <= '0;
      end else if (enter_setup) begin
        data_out_q <= setup_data;
      end
      if (state_d == StDone) begin
        result_q <= result_in;
      end
    end
  end

  assign go       = go_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign result   = result_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized bench for operand_sequencer: two instances (default and short timing),
// each driving a reactive calculator model, checked cycle by cycle against a phase list.
module tb_operand_sequencer;

  localparam int H0 = 2;
  localparam int G0 = 2;
  localparam int W0 = 4;
  localparam int H1 = 1;
  localparam int G1 = 1;
  localparam int W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, start0, start1;
  logic [7:0] op_a, op_b, op_c, op_x;
  logic [7:0] res_in0, res_in1;
  logic       go0, busy0, done0, go1, busy1, done1;
  logic [7:0] dout0, res0, dout1, res1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_res [2];

  operand_sequencer #(
    .HOLD_CYCLES(H0), .GAP_CYCLES(G0), .RESULT_WAIT(W0)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x), .result_in(res_in0),
    .go(go0), .data_out(dout0), .busy(busy0), .done(done0), .result(res0)
  );

  operand_sequencer #(
    .HOLD_CYCLES(H1), .GAP_CYCLES(G1), .RESULT_WAIT(W1)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x), .result_in(res_in1),
    .go(go1), .data_out(dout1), .busy(busy1), .done(done1), .result(res1)
  );

  // Calculator models: latch data_out on each go press; result valid 3 cycles after the
  // first low cycle of the X release, garbage before that.
  logic [7:0] cop0 [4];
  logic [7:0] cop1 [4];
  int ccnt0, clow0, ccnt1, clow1;
  logic cprev0, cprev1;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      ccnt0 <= 0; clow0 <= 0; cprev0 <= 1'b0; res_in0 <= 8'h00;
    end else begin
      if (go0 && !cprev0) begin
        cop0[(ccnt0 == 4) ? 0 : ccnt0] <= dout0;
        ccnt0 <= ((ccnt0 == 4) ? 0 : ccnt0) + 1;
        clow0 <= 0;
        if (ccnt0 == 4 || ccnt0 == 0) res_in0 <= 8'($urandom);
      end else if (!go0 && ccnt0 == 4) begin
        clow0 <= clow0 + 1;
        if (clow0 == 3) res_in0 <= cop0[0] * cop0[0] + cop0[1] * cop0[3] + cop0[2];
      end
      cprev0 <= go0;
    end
  end

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      ccnt1 <= 0; clow1 <= 0; cprev1 <= 1'b0; res_in1 <= 8'h00;
    end else begin
      if (go1 && !cprev1) begin
        cop1[(ccnt1 == 4) ? 0 : ccnt1] <= dout1;
        ccnt1 <= ((ccnt1 == 4) ? 0 : ccnt1) + 1;
        clow1 <= 0;
        if (ccnt1 == 4 || ccnt1 == 0) res_in1 <= 8'($urandom);
      end else if (!go1 && ccnt1 == 4) begin
        clow1 <= clow1 + 1;
        if (clow1 == 3) res_in1 <= cop1[0] * cop1[0] + cop1[1] * cop1[3] + cop1[2];
      end
      cprev1 <= go1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {go, busy, done, data_out, result}
  function automatic logic [18:0] obs(input int d);
    if (d == 0) return {go0, busy0, done0, dout0, res0};
    return {go1, busy1, done1, dout1, res1};
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic scramble_ops();
    op_a = 8'($urandom); op_b = 8'($urandom);
    op_c = 8'($urandom); op_x = 8'($urandom);
  endtask

  // Entered at a negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] x, input int poke,
                         input bit hold);
    int h, g, w, n;
    logic [7:0] ops [4];
    logic [7:0] exp_res;
    logic [18:0] pat [$];
    logic [18:0] o;
    h = (d == 0) ? H0 : H1;
    g = (d == 0) ? G0 : G1;
    w = (d == 0) ? W0 : W1;
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
    exp_res = a * a + b * x + c;
    for (int i = 0; i < 4; i++) begin
      pat.push_back({3'b010, ops[i], last_res[d]});
      for (int j = 0; j < h; j++) pat.push_back({3'b110, ops[i], last_res[d]});
      for (int j = 0; j < g; j++) pat.push_back({3'b010, ops[i], last_res[d]});
    end
    for (int j = 0; j < w; j++) pat.push_back({3'b010, ops[3], last_res[d]});
    pat.push_back({3'b011, 8'h00, exp_res});
    n = pat.size();

    op_a = a; op_b = b; op_c = c; op_x = x;
    set_start(d, 1'b1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        scramble_ops();
        if (!hold) set_start(d, 1'b0);
      end
      o = obs(d);
      if (k == n) o[15:8] = 8'h00;
      check($sformatf("d%0d_cyc%0d", d, k), 32'(o), 32'(pat[k-1]));
      if (poke != 0 && k == poke) begin
        set_start(d, 1'b1);
        scramble_ops();
      end
      if (poke != 0 && k == poke + 1) set_start(d, 1'b0);
    end
    last_res[d] = exp_res;
    @(negedge clk);
    check($sformatf("d%0d_idle_after_done", d), 32'(obs(d)), 32'({11'h000, exp_res}));
  endtask

  task automatic run_rand(input int d, input int poke, input bit hold);
    run_txn(d, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), poke, hold);
  endtask

  task automatic reset_mid_press();
    op_a = 8'h77; op_b = 8'h12; op_c = 8'h34; op_x = 8'h56;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    scramble_ops();
    @(negedge clk);
    check("pre_reset_in_press", 32'(obs(0)), 32'({3'b110, 8'h77, last_res[0]}));
    #2 resetn = 1'b0;
    #1;
    check("async_reset_d0", 32'(obs(0)), 32'd0);
    check("async_reset_d1", 32'(obs(1)), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_res[0] = 8'h00;
    last_res[1] = 8'h00;
    @(negedge clk);
    check("post_reset_idle", 32'(obs(0)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start0 = 1'b0; start1 = 1'b0;
    op_a = 8'h00; op_b = 8'h00; op_c = 8'h00; op_x = 8'h00;
    last_res[0] = 8'h00;
    last_res[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_d0", 32'(obs(0)), 32'd0);
    check("reset_d1", 32'(obs(1)), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_txn(0, 8'd3, 8'd0, 8'd5, 8'd0, 0, 1'b0);
    check("result_3_0_5_0", 32'(res0), 32'd14);
    run_txn(0, 8'd16, 8'd0, 8'd1, 8'd0, 0, 1'b0);
    check("result_wrap", 32'(res0), 32'd1);

    run_rand(0, 10, 1'b0);
    run_rand(0, 0, 1'b1);
    run_rand(0, 0, 1'b0);

    run_rand(1, 0, 1'b0);
    run_rand(1, 7, 1'b0);
    run_txn(1, 8'd3, 8'd0, 8'd5, 8'd0, 0, 1'b0);
    run_rand(1, 0, 1'b1);
    run_rand(1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_rand(i % 2, (i % 3 == 0) ? 5 : 0, 1'b0);
    end

    run_rand(0, 0, 1'b0);
    reset_mid_press();
    run_rand(0, 0, 1'b0);
    run_rand(1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
